sdram_port_share: RTL and testbench
===================================

# sdram_port_share

Round-robin sharer that multiplexes NCLI burst-level clients onto one upstream port of the SDRAM arbiter. Each client presents a complete burst access (bank/row/column, write flag, per-beat write data). The block grants one client at a time, forwards its request and beat handshakes, and counts BURST_LEN acknowledged beats before releasing the port. It sits between low-bandwidth masters (e.g. APU DMA, debug, framebuffer readback) and a single SRC port of the arbiter, so those masters share the port without consuming extra arbiter priority slots.

## Interface
- NCLI, 3, number of clients (2..8)
- BURST_LEN, 8, beats per burst; must equal the arbiter burst length
- CLK  in  1  clock, all logic on rising edge
- RESET_IN  in  1  asynchronous, active-high reset
- CLI_WRITE_IN  in  NCLI  per-client write (1) / read (0)
- CLI_ACS_IN  in  NCLI x SDRAM_PKG::dram_access_t  per-client access; .data is the current write beat
- CLI_REQ_IN  in  NCLI  per-client request, held until done
- CLI_ACK_OUT  out  NCLI  per-client beat acknowledge
- CLI_DATA_OUT  out  NCLI x SDRAM_PKG::data_t  read data, valid with CLI_ACK_OUT on reads
- CLI_DONE_OUT  out  NCLI  one-cycle pulse on the final beat of the client's burst
- PORT_WRITE_OUT  out  1  to arbiter SRC_WRITE_IN
- PORT_ACS_OUT  out  SDRAM_PKG::dram_access_t  to arbiter SRC_ACS_IN
- PORT_REQ_OUT  out  1  to arbiter SRC_REQ_IN
- PORT_ACK_IN  in  1  from arbiter SRC_ACK_OUT
- PORT_DATA_IN  in  SDRAM_PKG::data_t  from arbiter SRC_DATA_OUT

## Operation
- States: IDLE, BUSY. Registers: state, grant (clog2(NCLI) bits), rr_ptr (same width), beat_cnt (clog2(BURST_LEN) bits), seen_ack (1 bit).
- IDLE: PORT_REQ_OUT=0; PORT_ACS_OUT and PORT_WRITE_OUT = 0; all CLI_ACK_OUT/CLI_DONE_OUT = 0. If any CLI_REQ_IN bit is set, select the first set bit searching rr_ptr, rr_ptr+1, ... modulo NCLI; register grant; beat_cnt=0, seen_ack=0; go BUSY.
- BUSY: PORT_REQ_OUT = CLI_REQ_IN[grant]; PORT_WRITE_OUT = CLI_WRITE_IN[grant]; PORT_ACS_OUT = CLI_ACS_IN[grant] (combinational, so write-beat data tracks the client each cycle). CLI_ACK_OUT[grant] = PORT_ACK_IN; other ACK bits 0.
- Each cycle with PORT_ACK_IN in BUSY: seen_ack<=1; if beat_cnt==BURST_LEN-1 then CLI_DONE_OUT[grant]=1 (combinational, same cycle), state<=IDLE, rr_ptr<=grant+1 mod NCLI, beat_cnt<=0; else beat_cnt<=beat_cnt+1.
- Abort: in BUSY with seen_ack=0, PORT_ACK_IN=0, and CLI_REQ_IN[grant]=0 -> IDLE, no DONE, rr_ptr<=grant+1 mod NCLI.
- Drop mid-burst (seen_ack=1, REQ low): stay BUSY, keep forwarding PORT_ACK_IN and counting until BURST_LEN beats; DONE still pulses. Read beats in flight are never lost.
- PORT_ACK_IN in IDLE is ignored (not forwarded, not counted).
- CLI_DATA_OUT[i] = PORT_DATA_IN for every i (broadcast); clients qualify with their own ACK.
- Client contract: hold REQ and ACS stable (except .data per beat) from REQ rise until DONE, and drop REQ the cycle after DONE.

## Timing
- Reset: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, seen_ack=0; every output 0 while RESET_IN is high and in the first IDLE cycle after.
- Grant latency: REQ sampled in IDLE at edge N -> PORT_REQ_OUT high in cycle N+1.
- Release: DONE in cycle M -> IDLE in M+1 (PORT_REQ_OUT=0) -> next grant drives PORT_REQ_OUT in M+2. Exactly one dead cycle between bursts, which guarantees the arbiter sees REQ low between bursts.
- Ack/done path is purely combinational from PORT_ACK_IN; no added beat latency.
- Reset mid-burst: immediate return to IDLE; in-flight beats after reset are ignored.
- Simultaneous requests: lowest index at or above rr_ptr wins; a client that just finished has the lowest priority for the next grant.

## Test plan
- Reset: assert RESET_IN mid-BUSY with REQ[1]=1 -> all outputs 0 at once; after release, REQ[1] is granted again with rr_ptr=0 ordering.
- Single read: REQ[0]=1, write=0, bank 2 row 0x155 col 0x08; arbiter model acks 8 beats with data 0xA0..0xA7 after 5 cycles -> CLI_ACK_OUT[0] on 8 cycles, data matches, DONE[0] on beat 8, PORT_REQ_OUT low next cycle.
- Round-robin: REQ[0..2] all held -> grant order 0,1,2,0, with one PORT_REQ_OUT-low cycle between each burst.
- Write beats: REQ[2] write, client advances .data 0x10..0x17 on each ACK -> PORT_ACS_OUT.data equals the client value every cycle; DONE[2] after 8th ACK.
- Abort: REQ[1] granted, dropped before any ACK -> IDLE next cycle, no DONE, rr_ptr=2; a pending REQ[0] is granted after REQ[2] only if REQ[2] is set.
- Mid-burst drop: drop REQ[0] after 3 read beats -> remaining 5 beats still forwarded to CLI_ACK_OUT[0], DONE[0] on the 8th; a stray PORT_ACK_IN in IDLE produces no ACK output.

Source files
------------

// File: rtl/sdram_port_share.sv
// Round-robin sharer: multiplexes NCLI burst-level clients onto one upstream
// SDRAM arbiter port. One client owns the port from grant until its
// BURST_LEN-th acknowledged beat (or until it withdraws before any beat).
//
// Handshake: a client raises CLI_REQ_IN and holds it, with a stable access
// descriptor, until CLI_DONE_OUT. Each cycle with CLI_ACK_OUT high is one
// accepted beat: write data in .data is consumed, or read data on
// CLI_DATA_OUT is valid. DONE pulses together with the final ACK. The client
// drops REQ the cycle after DONE.

package SDRAM_PKG;
    typedef logic [15:0] data_t;

    typedef struct packed {
        logic [1:0]  bank;
        logic [12:0] row;
        logic [8:0]  col;
        data_t       data;
    } dram_access_t;
endpackage

module sdram_port_share #(
    parameter int NCLI      = 3,
    parameter int BURST_LEN = 8
) (
    input  logic                                 CLK,
    input  logic                                 RESET_IN,
    input  logic [NCLI-1:0]                      CLI_WRITE_IN,
    input  SDRAM_PKG::dram_access_t [NCLI-1:0]   CLI_ACS_IN,
    input  logic [NCLI-1:0]                      CLI_REQ_IN,
    output logic [NCLI-1:0]                      CLI_ACK_OUT,
    output SDRAM_PKG::data_t [NCLI-1:0]          CLI_DATA_OUT,
    output logic [NCLI-1:0]                      CLI_DONE_OUT,
    output logic                                 PORT_WRITE_OUT,
    output SDRAM_PKG::dram_access_t              PORT_ACS_OUT,
    output logic                                 PORT_REQ_OUT,
    input  logic                                 PORT_ACK_IN,
    input  SDRAM_PKG::data_t                     PORT_DATA_IN
);

    localparam int GW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state, state_n;
    logic [GW-1:0]   grant, grant_n;
    logic [GW-1:0]   rr_ptr, rr_n;
    logic [BW-1:0]   beat_cnt, beat_n;
    logic            seen_ack, seen_n;

    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic [GW-1:0]   next_ptr;
    int              cand;

    // Pointer handed to the next arbitration: the slot after the current owner
    assign next_ptr = (grant == GW'(NCLI - 1)) ? '0 : grant + GW'(1);

    // Round-robin search: first requesting client at or after rr_ptr
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NCLI; k++) begin
            cand = (int'(rr_ptr) + k) % NCLI;
            if (!sel_found && CLI_REQ_IN[GW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(cand);
            end
        end
    end

    // State and bookkeeping registers
    always_ff @(posedge CLK or posedge RESET_IN) begin
        if (RESET_IN) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            seen_ack <= 1'b0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            rr_ptr   <= rr_n;
            beat_cnt <= beat_n;
            seen_ack <= seen_n;
        end
    end

    // Next-state and port/client steering; ack and done are combinational from PORT_ACK_IN
    always_comb begin
        state_n        = state;
        grant_n        = grant;
        rr_n           = rr_ptr;
        beat_n         = beat_cnt;
        seen_n         = seen_ack;
        PORT_REQ_OUT   = 1'b0;
        PORT_WRITE_OUT = 1'b0;
        PORT_ACS_OUT   = '0;
        CLI_ACK_OUT    = '0;
        CLI_DONE_OUT   = '0;
        case (state)
            IDLE: begin
                // Acks arriving here belong to nobody and are dropped
                if (sel_found) begin
                    grant_n = sel_idx;
                    beat_n  = '0;
                    seen_n  = 1'b0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                PORT_REQ_OUT       = CLI_REQ_IN[grant];
                PORT_WRITE_OUT     = CLI_WRITE_IN[grant];
                PORT_ACS_OUT       = CLI_ACS_IN[grant];
                CLI_ACK_OUT[grant] = PORT_ACK_IN;
                if (PORT_ACK_IN) begin
                    seen_n = 1'b1;
                    if (beat_cnt == BW'(BURST_LEN - 1)) begin
                        CLI_DONE_OUT[grant] = 1'b1;
                        state_n             = IDLE;
                        rr_n                = next_ptr;
                        beat_n              = '0;
                    end else begin
                        beat_n = beat_cnt + BW'(1);
                    end
                end else if (!seen_ack && !CLI_REQ_IN[grant]) begin
                    // Withdrawn before the arbiter accepted anything: release at once.
                    // Once a beat has been seen the burst must run to completion.
                    state_n = IDLE;
                    rr_n    = next_ptr;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Read data is broadcast; each client qualifies it with its own ACK
    always_comb begin
        for (int i = 0; i < NCLI; i++) begin
            CLI_DATA_OUT[i] = PORT_DATA_IN;
        end
    end

endmodule

// File: tb/tb_sdram_port_share.sv
// Directed bench for sdram_port_share with a scoreboard of expected client beats.
module tb_sdram_port_share;

    logic                             clk = 1'b0;
    logic                             rst;
    logic [2:0]                       cli_write;
    SDRAM_PKG::dram_access_t [2:0]    cli_acs;
    logic [2:0]                       cli_req;
    logic [2:0]                       cli_ack;
    SDRAM_PKG::data_t [2:0]           cli_data;
    logic [2:0]                       cli_done;
    logic                             port_write;
    SDRAM_PKG::dram_access_t          port_acs;
    logic                             port_req;
    logic                             port_ack;
    SDRAM_PKG::data_t                 port_data;

    int checks   = 0;
    int failures = 0;

    // {ack vector, done vector, data seen by the acked client}
    logic [21:0] exp_q[$];
    logic [21:0] mon_exp;
    logic [21:0] mon_act;
    int          mon_idx;

    sdram_port_share #(.NCLI(3), .BURST_LEN(8)) dut (
        .CLK            (clk),
        .RESET_IN       (rst),
        .CLI_WRITE_IN   (cli_write),
        .CLI_ACS_IN     (cli_acs),
        .CLI_REQ_IN     (cli_req),
        .CLI_ACK_OUT    (cli_ack),
        .CLI_DATA_OUT   (cli_data),
        .CLI_DONE_OUT   (cli_done),
        .PORT_WRITE_OUT (port_write),
        .PORT_ACS_OUT   (port_acs),
        .PORT_REQ_OUT   (port_req),
        .PORT_ACK_IN    (port_ack),
        .PORT_DATA_IN   (port_data)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_port_req"},   64'(port_req),   64'd0);
        check({tag, "_port_write"}, 64'(port_write), 64'd0);
        check({tag, "_port_acs"},   64'(port_acs),   64'd0);
        check({tag, "_cli_ack"},    64'(cli_ack),    64'd0);
        check({tag, "_cli_done"},   64'(cli_done),   64'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic client_acs(input int i, input logic [1:0] b, input logic [12:0] r,
                              input logic [8:0] c, input logic [15:0] d);
        cli_acs[i].bank = b;
        cli_acs[i].row  = r;
        cli_acs[i].col  = c;
        cli_acs[i].data = d;
    endtask

    // Called one step after the edge that granted client cli; runs the arbiter side
    // of a full burst and returns one step after the edge ending the dead cycle.
    task automatic run_burst(input int cli, input logic [15:0] base, input int lat, input int drop_at);
        logic wr;
        wr = cli_write[cli];
        samp();
        check("grant_req",   64'(port_req),   64'd1);
        check("grant_acs",   64'(port_acs),   64'(cli_acs[cli]));
        check("grant_write", 64'(port_write), 64'(wr));
        repeat (lat) tick();
        for (int k = 0; k < 8; k++) begin
            if (drop_at >= 0 && k == drop_at) cli_req[cli] = 1'b0;
            port_ack = 1'b1;
            if (wr) begin
                cli_acs[cli].data = base + 16'(k);
                port_data = 16'h0000;
            end else begin
                port_data = base + 16'(k);
            end
            exp_q.push_back({3'(1 << cli), (k == 7) ? 3'(1 << cli) : 3'b000,
                             wr ? 16'h0000 : base + 16'(k)});
            samp();
            if (wr) check("wr_data", 64'(port_acs.data), 64'(base + 16'(k)));
            if (drop_at >= 0 && k >= drop_at) check("drop_req_low", 64'(port_req), 64'd0);
            tick();
        end
        port_ack = 1'b0;
        port_data = 16'h0000;
        cli_req[cli] = 1'b0;
        samp();
        check("dead_cycle_req", 64'(port_req), 64'd0);
        tick();
    endtask

    // Monitor: every client ACK pops one expected beat
    always @(negedge clk) begin
        if (cli_ack != 3'b000) begin
            mon_idx = 0;
            for (int i = 0; i < 3; i++) if (cli_ack[i]) mon_idx = i;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ack actual=%b required=000", cli_ack);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_act = {cli_ack, cli_done, cli_data[mon_idx]};
                if (mon_act !== mon_exp) begin
                    failures++;
                    $display("FAIL beat actual=%h required=%h", mon_act, mon_exp);
                end
            end
        end else if (cli_done != 3'b000) begin
            checks++;
            failures++;
            $display("FAIL done_without_ack actual=%b required=000", cli_done);
        end
    end

    // Stimulus
    initial begin
        rst = 1'b1;
        cli_write = '0;
        cli_acs = '0;
        cli_req = '0;
        port_ack = 1'b0;
        port_data = '0;

        // Reset state
        repeat (2) tick();
        samp();
        check_idle("rst_hold");
        tick();
        rst = 1'b0;
        samp();
        check_idle("rst_first_idle");

        // Single read, client 0, bank 2 row 0x155 col 0x08, data A0..A7
        tick();
        client_acs(0, 2'd2, 13'h155, 9'h008, 16'h0000);
        cli_write[0] = 1'b0;
        cli_req[0] = 1'b1;
        samp();
        check("pre_grant_req", 64'(port_req), 64'd0);
        tick();
        run_burst(0, 16'h00A0, 5, -1);

        // Write burst, client 2, data 0x10..0x17 (rr_ptr=1 -> 2 found)
        client_acs(2, 2'd1, 13'h0AA, 9'h010, 16'h0010);
        cli_write[2] = 1'b1;
        cli_req[2] = 1'b1;
        samp();
        check("pre_grant_wr", 64'(port_req), 64'd0);
        tick();
        run_burst(2, 16'h0010, 1, -1);

        // Round-robin with all three requesting: order 0,1,2,0
        client_acs(0, 2'd0, 13'h100, 9'h000, 16'h0000);
        client_acs(1, 2'd1, 13'h101, 9'h004, 16'h0000);
        client_acs(2, 2'd2, 13'h102, 9'h00C, 16'h0000);
        cli_write = 3'b000;
        cli_req = 3'b111;
        samp();
        tick();
        run_burst(0, 16'h00B0, 1, -1);
        cli_req[0] = 1'b1;
        check("rr_second_row", 64'(port_acs.row), 64'h101);
        run_burst(1, 16'h00C0, 1, -1);
        check("rr_third_row", 64'(port_acs.row), 64'h102);
        run_burst(2, 16'h00D0, 1, -1);
        check("rr_fourth_row", 64'(port_acs.row), 64'h100);
        run_burst(0, 16'h00E0, 1, -1);

        // Abort: client 1 granted (rr_ptr=1), withdraws before any ACK
        cli_req[0] = 1'b1;
        cli_req[1] = 1'b1;
        samp();
        tick();
        samp();
        check("abort_grant_row", 64'(port_acs.row), 64'h101);
        check("abort_grant_req", 64'(port_req), 64'd1);
        tick();
        cli_req[1] = 1'b0;
        samp();
        check("abort_req_comb", 64'(port_req), 64'd0);
        tick();
        cli_req[2] = 1'b1;
        samp();
        check_idle("abort_idle");
        tick();
        // rr_ptr=2: client 2 wins over the pending client 0
        run_burst(2, 16'h0020, 2, -1);
        run_burst(0, 16'h0030, 1, -1);

        // Mid-burst drop: client 0 drops REQ after 3 beats
        cli_req[0] = 1'b1;
        samp();
        tick();
        run_burst(0, 16'h0040, 1, 3);
        // Stray ACK while idle
        port_ack = 1'b1;
        port_data = 16'h00FF;
        samp();
        check("stray_ack", 64'(cli_ack), 64'd0);
        check("stray_done", 64'(cli_done), 64'd0);
        tick();
        port_ack = 1'b0;
        port_data = 16'h0000;
        samp();
        check_idle("after_stray");
        tick();

        // Reset in the middle of a burst for client 1
        cli_req[1] = 1'b1;
        samp();
        tick();
        for (int k = 0; k < 2; k++) begin
            port_ack = 1'b1;
            port_data = 16'h0050 + 16'(k);
            exp_q.push_back({3'b010, 3'b000, 16'h0050 + 16'(k)});
            samp();
            tick();
        end
        rst = 1'b1;
        #1;
        check_idle("rst_async");
        samp();
        check_idle("rst_mid");
        tick();
        rst = 1'b0;
        samp();
        check_idle("rst_release_idle");
        tick();
        port_ack = 1'b0;
        port_data = 16'h0000;
        run_burst(1, 16'h0060, 1, -1);

        repeat (3) tick();
        check("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
